score_counter: RTL



---
 rtl/snake_pkg.sv | 8 +
 rtl/seg7_decoder.sv | 26 ++
 rtl/score_counter.sv | 105 ++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: shared constants between the snake game master FSM and its helpers.
package snake_pkg;
    localparam logic [1:0] MSM_IDLE = 2'd0;
    localparam logic [1:0] MSM_GAME = 2'd1;
    localparam logic [1:0] MSM_WIN = 2'd2;
    localparam int SCORE_W = 4;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: 4-bit digit plus blank flag to active-low cathodes {dp,g..a}.
module seg7_decoder
    import snake_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [7:0] hex_o
);
    always_comb begin
        hex_o = SEG_BLANK;
        if (!blank_i)
            case (digit_i)
                4'd0: hex_o = 8'hC0;
                4'd1: hex_o = 8'hF9;
                4'd2: hex_o = 8'hA4;
                4'd3: hex_o = 8'hB0;
                4'd4: hex_o = 8'h99;
                4'd5: hex_o = 8'h92;
                4'd6: hex_o = 8'h82;
                4'd7: hex_o = 8'hF8;
                4'd8: hex_o = 8'h80;
                4'd9: hex_o = 8'h90;
                default: hex_o = SEG_BLANK;
            endcase
    end
endmodule

// File: rtl/score_counter.sv
// score_counter: counts target hits during GAME, saturating at WIN_SCORE.
// Optional seven-segment score display when SCORE_SEG7_EN is defined.
module score_counter
    import snake_pkg::*;
#(
    parameter int WIN_SCORE = 3,
    parameter int REFRESH_DIV = 100000
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [1:0]         MSM_STATE,
    input  logic               REACHED_TARGET,
    output logic [SCORE_W-1:0] SCORE,
    output logic               TARGET_ACK,
    output logic [3:0]         SEG_SELECT,
    output logic [7:0]         HEX_OUT
);
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_WAIT_LOW, S_FROZEN} state_t;

    state_t state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic hit_q, ack_q, ack_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            score_q <= '0;
            hit_q <= 1'b0;
            ack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            hit_q <= REACHED_TARGET;
            ack_q <= ack_d;
        end
    end

    // Clear beats freeze beats counting; encoding 3 behaves as IDLE.
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        ack_d = 1'b0;
        if (MSM_STATE != MSM_GAME && MSM_STATE != MSM_WIN) begin
            state_d = S_IDLE;
            score_d = '0;
        end else if (MSM_STATE == MSM_WIN) begin
            state_d = S_FROZEN;
        end else
            case (state_q)
                S_IDLE: state_d = S_PLAY;
                S_PLAY:
                    if (hit_q) begin
                        score_d = score_q >= SCORE_W'(WIN_SCORE) ? score_q : score_q + 1'b1;
                        ack_d = 1'b1;
                        state_d = S_WAIT_LOW;
                    end
                S_WAIT_LOW: state_d = hit_q ? S_WAIT_LOW : S_PLAY;
                default: state_d = S_FROZEN;
            endcase
    end

    assign SCORE = score_q;
    assign TARGET_ACK = ack_q;

`ifdef SCORE_SEG7_EN
    localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic digit_q, blank, wrap;
    logic [3:0] seg_q, dig;
    logic [7:0] hex_q, hex_d;

    assign wrap = cnt_q == CW'(REFRESH_DIV - 1);
    assign dig = digit_q ? score_q / 4'd10 : score_q % 4'd10;
    assign blank = digit_q && score_q < 4'd10;

    seg7_decoder u_dec (
        .digit_i(dig),
        .blank_i(blank),
        .hex_o  (hex_d)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q <= '0;
            digit_q <= 1'b0;
            seg_q <= 4'hF;
            hex_q <= SEG_BLANK;
        end else begin
            cnt_q <= wrap ? '0 : cnt_q + 1'b1;
            digit_q <= wrap ? ~digit_q : digit_q;
            seg_q <= digit_q ? 4'b1101 : 4'b1110;
            hex_q <= hex_d;
        end
    end

    assign SEG_SELECT = seg_q;
    assign HEX_OUT = hex_q;
`else
    logic unused_refresh;
    assign unused_refresh = |REFRESH_DIV;
    assign SEG_SELECT = 4'hF;
    assign HEX_OUT = SEG_BLANK;
`endif
endmodule
